neighbourhood_window_reader: RTL and testbench

//  Read side of the frame buffer. Runs in the readClk domain from clockGenerator.

---
 rtl/neighbourhood_window_reader_pkg.sv | 20 ++
 rtl/neighbourhood_window_reader_if.sv | 29 ++
 rtl/neighbourhood_window_reader_line_buffer.sv | 25 ++
 rtl/neighbourhood_window_reader.sv | 190 +++++++++++++++++++
 tb/tb_neighbourhood_window_reader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/neighbourhood_window_reader_pkg.sv
// Shared defaults, FSM encoding and window indexing for the frame-buffer read side.
package neighbourhood_window_reader_pkg;
  localparam int PIX_W_DEF      = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int ADDR_W_DEF     = 19;
  localparam int COORD_W        = 16;
  localparam int WIN_N          = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Flat element index of window cell (row, col), row 0 = top, col 0 = left.
  function automatic int win_idx(input int row, input int col);
    return 3 * row + col;
  endfunction
endpackage

// File: rtl/neighbourhood_window_reader_if.sv
// Control, RAM read port and window stream of the neighbourhood window reader.
interface neighbourhood_window_reader_if
  import neighbourhood_window_reader_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic                     start;
  logic                     busy;
  logic                     frame_done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [PIX_W-1:0]         rd_data;
  logic                     win_valid;
  logic                     win_ready;
  logic [WIN_N*PIX_W-1:0]   win_data;
  logic [COORD_W-1:0]       win_row;
  logic [COORD_W-1:0]       win_col;

  modport master (
    input  start, rd_data, win_ready,
    output busy, frame_done, rd_en, rd_addr, win_valid, win_data, win_row, win_col
  );

  modport slave (
    output start, rd_data, win_ready,
    input  busy, frame_done, rd_en, rd_addr, win_valid, win_data, win_row, win_col
  );
endinterface

// File: rtl/neighbourhood_window_reader_line_buffer.sv
// One image row of pixels indexed by column; synchronous write, asynchronous read at the same index.
module neighbourhood_window_reader_line_buffer
  import neighbourhood_window_reader_pkg::*;
#(
  parameter int PIX_W     = PIX_W_DEF,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IDX_W     = $clog2(IMG_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);
  logic [PIX_W-1:0] r_mem [IMG_WIDTH];

  // Row storage write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/neighbourhood_window_reader.sv
// Fetches a frame in raster order and streams 3x3 neighbourhood windows over valid/ready.
module neighbourhood_window_reader
  import neighbourhood_window_reader_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                          i_read_clk,
  input  logic                          i_reset,
  neighbourhood_window_reader_if.master io_bus
);
  localparam int                 IDX_W        = $clog2(IMG_WIDTH);
  localparam logic [ADDR_W-1:0]  ADDR_LAST    = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] COL_LAST     = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] WIN_ROW_LAST = COORD_W'(IMG_HEIGHT - 2);
  localparam logic [COORD_W-1:0] WIN_COL_LAST = COORD_W'(IMG_WIDTH - 2);

  state_e             r_state;
  state_e             w_state_next;
  logic               w_adv;
  logic               w_rd_en;
  logic               w_start_ok;
  logic               w_consume;
  logic               w_win_hs;
  logic               w_last_hs;
  logic               w_emit;
  logic               r_pend;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               r_win_valid;
  logic [COORD_W-1:0] r_win_row;
  logic [COORD_W-1:0] r_win_col;
  logic               r_frame_done;
  logic [PIX_W-1:0]   r_win [WIN_N];
  logic [PIX_W-1:0]   w_col_new [3];
  logic [PIX_W-1:0]   w_lb0_q;
  logic [PIX_W-1:0]   w_lb1_q;
  logic [IDX_W-1:0]   w_idx;

  assign w_adv     = !r_win_valid || io_bus.win_ready;
  assign w_consume = r_pend && w_adv;
  assign w_win_hs  = r_win_valid && io_bus.win_ready;
  assign w_last_hs = w_win_hs && (r_win_row == WIN_ROW_LAST) && (r_win_col == WIN_COL_LAST);
  assign w_emit    = w_consume && (r_row >= 16'd2) && (r_col >= 16'd2);
  assign w_idx     = r_col[IDX_W-1:0];

  // lb1 holds row r-2 and lb0 row r-1 at the current column
  assign w_col_new[0] = w_lb1_q;
  assign w_col_new[1] = w_lb0_q;
  assign w_col_new[2] = io_bus.rd_data;

  neighbourhood_window_reader_line_buffer #(
    .PIX_W     (PIX_W),
    .IMG_WIDTH (IMG_WIDTH),
    .IDX_W     (IDX_W)
  ) u_lb0 (
    .i_clk   (i_read_clk),
    .i_we    (w_consume),
    .i_idx   (w_idx),
    .i_wdata (io_bus.rd_data),
    .o_rdata (w_lb0_q)
  );

  neighbourhood_window_reader_line_buffer #(
    .PIX_W     (PIX_W),
    .IMG_WIDTH (IMG_WIDTH),
    .IDX_W     (IDX_W)
  ) u_lb1 (
    .i_clk   (i_read_clk),
    .i_we    (w_consume),
    .i_idx   (w_idx),
    .i_wdata (w_lb0_q),
    .o_rdata (w_lb1_q)
  );

  // FSM state register
  always_ff @(posedge i_read_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state, start acceptance and read issue
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_start_ok   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_start_ok   = 1'b1;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_rd_en = w_adv;
        if (w_adv && (r_rd_addr == ADDR_LAST)) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (w_last_hs) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address/position counters, pending-pixel flag and window output registers
  always_ff @(posedge i_read_clk) begin
    if (i_reset) begin
      r_pend       <= 1'b0;
      r_rd_addr    <= '0;
      r_row        <= 16'd0;
      r_col        <= 16'd0;
      r_win_valid  <= 1'b0;
      r_win_row    <= 16'd0;
      r_win_col    <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_DRAIN) && w_last_hs;
      if (w_start_ok) begin
        r_rd_addr <= '0;
        r_row     <= 16'd0;
        r_col     <= 16'd0;
      end else begin
        if (w_rd_en) begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
        if (w_consume) begin
          if (r_col == COL_LAST) begin
            r_col <= 16'd0;
            r_row <= r_row + 16'd1;
          end else begin
            r_col <= r_col + 16'd1;
          end
        end
      end
      if (w_rd_en) begin
        r_pend <= 1'b1;
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_row   <= r_row - 16'd1;
        r_win_col   <= r_col - 16'd1;
      end else begin
        r_win_valid <= r_win_valid && !io_bus.win_ready;
      end
    end
  end

  // Window shifts left by one column per consumed pixel; contents need no reset
  always_ff @(posedge i_read_clk) begin
    if (w_consume) begin
      for (int i = 0; i < 3; i++) begin
        r_win[win_idx(i, 0)] <= r_win[win_idx(i, 1)];
        r_win[win_idx(i, 1)] <= r_win[win_idx(i, 2)];
        r_win[win_idx(i, 2)] <= w_col_new[i];
      end
    end
  end

  for (genvar k = 0; k < WIN_N; k++) begin : g_win_out
    assign io_bus.win_data[k*PIX_W +: PIX_W] = r_win[k];
  end

  assign io_bus.busy       = (r_state != ST_IDLE);
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.rd_en      = w_rd_en;
  assign io_bus.rd_addr    = r_rd_addr;
  assign io_bus.win_valid  = r_win_valid;
  assign io_bus.win_row    = r_win_row;
  assign io_bus.win_col    = r_win_col;
endmodule

// File: tb/tb_neighbourhood_window_reader.sv
// Directed bench: 8x6 frame reader with backpressure, restart and reset cases, plus a 3x3 instance.
module tb_neighbourhood_window_reader;
  localparam int TW   = 8;
  localparam int TH   = 6;
  localparam int NWIN = (TW - 2) * (TH - 2);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_idx;
  int   exp_addr;
  int   done_cnt;
  int   first_valid;
  int   stalls_seen;
  logic [71:0] first_data;

  neighbourhood_window_reader_if #(.PIX_W(8), .ADDR_W(6)) a_if ();
  neighbourhood_window_reader_if #(.PIX_W(8), .ADDR_W(4)) b_if ();

  neighbourhood_window_reader #(
    .PIX_W(8), .IMG_WIDTH(TW), .IMG_HEIGHT(TH), .ADDR_W(6)
  ) u_dut_a (
    .i_read_clk (clk),
    .i_reset    (rst),
    .io_bus     (a_if)
  );

  neighbourhood_window_reader #(
    .PIX_W(8), .IMG_WIDTH(3), .IMG_HEIGHT(3), .ADDR_W(4)
  ) u_dut_b (
    .i_read_clk (clk),
    .i_reset    (rst),
    .io_bus     (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: mem[a] = a mod 256, output held while rd_en is low
  always @(posedge clk) begin
    if (a_if.rd_en) a_if.rd_data <= 8'(a_if.rd_addr);
    if (b_if.rd_en) b_if.rd_data <= 8'(b_if.rd_addr);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int idx);
    int r;
    int c;
    exp_win = '0;
    r = 1 + idx / (TW - 2);
    c = 1 + idx % (TW - 2);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_win[(3*i+j)*8 +: 8] = 8'(((r - 1 + i) * TW + (c - 1 + j)) % 256);
  endfunction

  task automatic mon_a(input int cyc_rel, input int mode);
    if (a_if.rd_en) begin
      check_eq("rd_addr", a_if.rd_addr, exp_addr);
      exp_addr++;
    end
    if (a_if.win_valid) begin
      if (first_valid < 0) begin
        first_valid = cyc_rel;
        first_data  = a_if.win_data;
      end
      if (exp_idx < NWIN) begin
        check_eq("win_data", a_if.win_data, exp_win(exp_idx));
        check_eq("win_row", a_if.win_row, 1 + exp_idx / (TW - 2));
        check_eq("win_col", a_if.win_col, 1 + exp_idx % (TW - 2));
      end else begin
        check_eq("win_count_extra", exp_idx, NWIN - 1);
      end
      if (!a_if.win_ready) begin
        stalls_seen++;
        check_eq("rd_en_in_stall", a_if.rd_en, 0);
      end else begin
        exp_idx++;
      end
    end
    if (a_if.frame_done) begin
      done_cnt++;
      check_eq("busy_at_done", a_if.busy, 0);
      check_eq("wins_at_done", exp_idx, NWIN);
    end
    if (mode == 1 && cyc_rel == 0) check_eq("busy_cycle0", a_if.busy, 0);
    if (mode == 1 && cyc_rel == 1) check_eq("busy_cycle1", a_if.busy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, a_if.busy, 0);
    check_eq({tag, "_frame_done"}, a_if.frame_done, 0);
    check_eq({tag, "_rd_en"}, a_if.rd_en, 0);
    check_eq({tag, "_win_valid"}, a_if.win_valid, 0);
    check_eq({tag, "_rd_addr"}, a_if.rd_addr, 0);
    check_eq({tag, "_win_row"}, a_if.win_row, 0);
    check_eq({tag, "_win_col"}, a_if.win_col, 0);
  endtask

  // mode: 1 ready=1, 2 random ready, 3 stall at first window, 4 restart cases, 5 reset at 10th window
  task automatic run_frames(input int mode, input int n_frames, input int budget);
    int  stall;
    bit  rst_hit;
    stall       = 0;
    rst_hit     = 1'b0;
    done_cnt    = 0;
    exp_idx     = 0;
    exp_addr    = 0;
    first_valid = -1;
    stalls_seen = 0;
    for (int cyc = 0; cyc < budget && done_cnt < n_frames; cyc++) begin
      @(posedge clk);
      #1;
      a_if.start = (cyc == 0) || (mode == 4 && cyc == 30) ||
                   (mode == 4 && a_if.frame_done && done_cnt == 0);
      if (mode == 2) begin
        a_if.win_ready = 1'($urandom_range(0, 1));
      end else if (mode == 3 && a_if.win_valid && exp_idx == 0 && stall < 20) begin
        a_if.win_ready = 1'b0;
        stall++;
      end else begin
        a_if.win_ready = 1'b1;
      end
      if (mode == 5 && a_if.win_valid && exp_idx == 9) rst = 1'b1;
      #1;
      mon_a(cyc, mode);
      if (mode == 4 && a_if.start && a_if.frame_done) begin
        exp_idx  = 0;
        exp_addr = 0;
      end
      if (rst) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        rst_hit = 1'b1;
        break;
      end
    end
    a_if.start     = 1'b0;
    a_if.win_ready = 1'b1;
    if (mode == 5) check_eq("reset_reached", rst_hit, 1);
    else if (done_cnt < n_frames) check_eq("frame_timeout", done_cnt, n_frames);
  endtask

  initial begin
    logic [71:0] w_first;
    logic [71:0] w_small;
    int b_wins;
    int b_done;
    int b_first;
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    a_if.start     = 1'b0;
    a_if.win_ready = 1'b1;
    b_if.start     = 1'b0;
    b_if.win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Test 1: free-running frame
    run_frames(1, 1, 300);
    w_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    check_eq("first_win_cycle", first_valid, 21);
    check_eq("first_win_data", first_data, w_first);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      mon_a(100 + i, 0);
    end
    check_eq("frame_done_once", done_cnt, 1);

    // Test 2: random backpressure
    run_frames(2, 1, 800);
    // Test 3: 20-cycle stall on the first window
    run_frames(3, 1, 400);
    check_eq("stall_cycles", stalls_seen, 20);
    // Test 4: start while busy ignored, start on frameDone accepted
    run_frames(4, 2, 600);
    check_eq("frames_chained", done_cnt, 2);
    // Test 5: reset at the 10th window, then a full frame
    run_frames(5, 1, 300);
    run_frames(1, 1, 300);

    // Test 6: 3x3 image gives a single window
    w_small = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    b_wins  = 0;
    b_done  = 0;
    b_first = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk);
      #1;
      b_if.start     = (cyc == 0);
      b_if.win_ready = 1'b1;
      #1;
      if (b_if.win_valid) begin
        b_wins++;
        if (b_first < 0) b_first = cyc;
        check_eq("small_win_data", b_if.win_data, w_small);
        check_eq("small_win_row", b_if.win_row, 1);
        check_eq("small_win_col", b_if.win_col, 1);
      end
      if (b_if.frame_done) begin
        b_done++;
        break;
      end
    end
    b_if.start = 1'b0;
    check_eq("small_win_count", b_wins, 1);
    check_eq("small_frame_done", b_done, 1);
    check_eq("small_first_cycle", b_first, 11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
